// File: rtl/mem_access_sequencer.sv
// mem_access_sequencer: multi-cycle load/store sequencer with read-modify-write sub-word stores.
// Define MEM_ACCESS_SIGN_EXT_EN to sign-extend LB/LH results (zero-extended otherwise).
module mem_access_sequencer #(
  parameter int MEM_LAT = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [31:0] o_mem_wdata,
  input  logic [31:0] i_mem_rdata,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic [31:0] o_rdata
);
  localparam logic [1:0] S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3;
  localparam logic [2:0] OP_LB = 3'd1, OP_LH = 3'd2, OP_SH = 3'd3, OP_SW = 3'd5;
  logic [1:0]  r_state;
  logic [2:0]  r_op;
  logic [31:2] r_addr;
  logic [31:0] r_wdata, r_rd, r_rdata;
  logic [3:0]  r_cnt;
  logic        r_err;
  logic [31:0] w_ld;
  logic        w_is_load, w_unused;
  assign w_is_load = r_op < OP_SH;
  assign w_unused  = ^i_addr[1:0];
`ifdef MEM_ACCESS_SIGN_EXT_EN
  assign w_ld = r_op == OP_LB ? {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]} :
                r_op == OP_LH ? {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]} : i_mem_rdata;
`else
  assign w_ld = r_op == OP_LB ? {24'd0, i_mem_rdata[7:0]} :
                r_op == OP_LH ? {16'd0, i_mem_rdata[15:0]} : i_mem_rdata;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_op    <= 3'd0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_rdata <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (i_req) begin
          r_op    <= i_op;
          r_addr  <= i_addr[31:2];
          r_wdata <= i_wdata;
          r_err   <= i_op > OP_SW;
          r_cnt   <= 4'(MEM_LAT - 1);
          r_state <= i_op > OP_SW ? S_DONE : i_op == OP_SW ? S_WR : S_RD;
        end
        S_RD: if (r_cnt == 4'd0) begin
          r_rd    <= i_mem_rdata;
          r_rdata <= w_is_load ? w_ld : r_rdata;
          r_state <= w_is_load ? S_DONE : S_WR;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
        S_WR:    r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign o_mem_addr  = {r_addr, 2'b00};
  assign o_mem_wr    = r_state == S_WR;
  assign o_mem_wdata = !o_mem_wr     ? 32'd0 :
                       r_op == OP_SW ? r_wdata :
                       r_op == OP_SH ? {r_rd[31:16], r_wdata[15:0]} : {r_rd[31:8], r_wdata[7:0]};
  assign o_busy  = r_state != S_IDLE;
  assign o_done  = r_state == S_DONE;
  assign o_err   = o_done & r_err;
  assign o_rdata = r_rdata;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// tb_mem_access_sequencer: drives MEM_LAT=1 and MEM_LAT=3 sequencers in lockstep against a memory model.
module tb_mem_access_sequencer;
  typedef struct {
    int          done_k;
    int          wr_k;
    logic        err;
    logic [31:0] rdata;
    logic [31:0] wdata;
  } exp_t;

  logic        clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] mem_addr[2], mem_wdata[2], mem_rdata[2], rdata[2];
  logic        mem_wr[2], busy[2], done[2], err[2];
  logic [31:0] mem[2][32];
  logic [31:0] sh[32];
  int          rc[2];
  logic [31:0] exp_rd[2];
  exp_t        q[2][$];
  int          n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  function automatic int lat(input int d);
    return d == 0 ? 1 : 3;
  endfunction

  function automatic logic [31:0] init_word(input int i);
    case (i)
      4:       return 32'hDEADBEEF;
      8:       return 32'h12345680;
      12:      return 32'h11223344;
      16:      return 32'h00000000;
      20:      return 32'h55667788;
      default: return 32'h01010101 * i;
    endcase
  endfunction

  mem_access_sequencer #(.MEM_LAT(1)) u_lat1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_mem_addr(mem_addr[0]), .o_mem_wr(mem_wr[0]), .o_mem_wdata(mem_wdata[0]),
    .i_mem_rdata(mem_rdata[0]), .o_busy(busy[0]), .o_done(done[0]), .o_err(err[0]),
    .o_rdata(rdata[0]));
  mem_access_sequencer #(.MEM_LAT(3)) u_lat3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_op(op), .i_addr(addr), .i_wdata(wdata),
    .o_mem_addr(mem_addr[1]), .o_mem_wr(mem_wr[1]), .o_mem_wdata(mem_wdata[1]),
    .i_mem_rdata(mem_rdata[1]), .o_busy(busy[1]), .o_done(done[1]), .o_err(err[1]),
    .o_rdata(rdata[1]));

  // Read data is only valid in the MEM_LAT-th cycle after the address is first presented.
  assign mem_rdata[0] = rc[0] == 0 ? mem[0][mem_addr[0][6:2]] : 32'hBAD0BAD0;
  assign mem_rdata[1] = rc[1] == 2 ? mem[1][mem_addr[1][6:2]] : 32'hBAD0BAD0;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      rc[d] <= (busy[d] && !mem_wr[d]) ? rc[d] + 1 : 0;
      if (!rst_n)
        for (int i = 0; i < 32; i++) mem[d][i] <= init_word(i);
      else if (mem_wr[d])
        mem[d][mem_addr[d][6:2]] <= mem_wdata[d];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] wd, input bit poke);
    exp_t        e;
    int          wr_k[2], nwr[2];
    logic [31:0] wr_d[2];
    bit          fin[2];
    logic [4:0]  ix = a[6:2];
    logic [31:0] w = sh[ix];
    logic [31:0] ld, st;
`ifdef MEM_ACCESS_SIGN_EXT_EN
    ld = o == 3'd1 ? {{24{w[7]}}, w[7:0]} : o == 3'd2 ? {{16{w[15]}}, w[15:0]} : w;
`else
    ld = o == 3'd1 ? {24'd0, w[7:0]} : o == 3'd2 ? {16'd0, w[15:0]} : w;
`endif
    st = o == 3'd5 ? wd : o == 3'd3 ? {w[31:16], wd[15:0]} : {w[31:8], wd[7:0]};
    for (int d = 0; d < 2; d++) begin
      e.err   = o > 3'd5;
      e.wdata = st;
      e.done_k = o > 3'd5 ? 1 : o == 3'd5 ? 2 : o >= 3'd3 ? lat(d) + 2 : lat(d) + 1;
      e.wr_k   = o == 3'd5 ? 1 : (o == 3'd3 || o == 3'd4) ? lat(d) + 1 : 0;
      if (o <= 3'd2) exp_rd[d] = ld;
      e.rdata = exp_rd[d];
      q[d].push_back(e);
      wr_k[d] = 0; nwr[d] = 0; wr_d[d] = '0; fin[d] = 1'b0;
    end
    if (o >= 3'd3 && o <= 3'd5) sh[ix] = st;
    @(negedge clk);
    req = 1'b1; op = o; addr = a; wdata = wd;
    @(posedge clk);
    for (int k = 1; k <= 12 && !(fin[0] && fin[1]); k++) begin
      @(negedge clk);
      req = poke && k == 1;
      op = 3'd0;
      for (int d = 0; d < 2; d++) if (!fin[d]) begin
        if (mem_wr[d]) begin nwr[d]++; wr_k[d] = k; wr_d[d] = mem_wdata[d]; end
        if (done[d]) begin
          e = q[d].pop_front();
          fin[d] = 1'b1;
          chk($sformatf("done_cycle[%0d]", d), k, e.done_k);
          chk($sformatf("err[%0d]", d), {31'd0, err[d]}, {31'd0, e.err});
          chk($sformatf("rdata[%0d]", d), rdata[d], e.rdata);
          chk($sformatf("mem_addr[%0d]", d), mem_addr[d], {a[31:2], 2'b00});
          chk($sformatf("idle_wdata[%0d]", d), mem_wdata[d], 32'd0);
          chk($sformatf("wr_pulses[%0d]", d), nwr[d], e.wr_k > 0 ? 1 : 0);
          if (e.wr_k > 0) begin
            chk($sformatf("wr_cycle[%0d]", d), wr_k[d], e.wr_k);
            chk($sformatf("wr_data[%0d]", d), wr_d[d], e.wdata);
          end
        end
      end
    end
    req = 1'b0;
    for (int d = 0; d < 2; d++) chk($sformatf("completed[%0d]", d), {31'd0, fin[d]}, 32'd1);
    @(negedge clk);
    for (int d = 0; d < 2; d++) chk($sformatf("idle_after[%0d]", d), {31'd0, busy[d]}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) sh[i] = init_word(i);
    exp_rd[0] = '0; exp_rd[1] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy", {31'd0, busy[d]}, 32'd0);
      chk("rst_done", {31'd0, done[d]}, 32'd0);
      chk("rst_err", {31'd0, err[d]}, 32'd0);
      chk("rst_mem_wr", {31'd0, mem_wr[d]}, 32'd0);
      chk("rst_mem_addr", mem_addr[d], 32'd0);
      chk("rst_mem_wdata", mem_wdata[d], 32'd0);
      chk("rst_rdata", rdata[d], 32'd0);
    end
    rst_n = 1'b1;
    // SB aborted by reset while both instances are still reading.
    @(negedge clk);
    req = 1'b1; op = 3'd4; addr = 32'h50; wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    for (int d = 0; d < 2; d++) chk("abort_pre_busy", {31'd0, busy[d]}, 32'd1);
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("abort_busy", {31'd0, busy[d]}, 32'd0);
      chk("abort_mem_wr", {31'd0, mem_wr[d]}, 32'd0);
      chk("abort_rdata", rdata[d], 32'd0);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) chk("abort_quiet", {30'd0, done[d], mem_wr[d]}, 32'd0);
    end
    rst_n = 1'b1;
    run(3'd0, 32'h80000013, 32'h0, 1'b0);
    run(3'd1, 32'h20, 32'h0, 1'b0);
    run(3'd2, 32'h22, 32'h0, 1'b0);
    run(3'd4, 32'h30, 32'hAABBCCDD, 1'b0);
    run(3'd3, 32'h30, 32'hAABBCCDD, 1'b0);
    run(3'd5, 32'h40, 32'hCAFEF00D, 1'b1);
    run(3'd7, 32'h10, 32'h12345678, 1'b0);
    run(3'd0, 32'h40, 32'h0, 1'b0);
    run(3'd6, 32'h20, 32'h0, 1'b0);
    run(3'd1, 32'h11, 32'h0, 1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
